// File: rtl/msi001_pkg.sv
// Shared MSI001 definitions: sequencer state encoding, serializer word width
// and the default register words used to bring the tuner up.
package msi001_pkg;

    localparam int MSI001_WORD_W = 24;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERR   = 3'd6;

    localparam logic [MSI001_WORD_W-1:0] MSI001_CFG_WORD0 = 24'hEBAEAB;
    localparam logic [MSI001_WORD_W-1:0] MSI001_CFG_WORD1 = 24'h09AFAB;
    localparam logic [MSI001_WORD_W-1:0] MSI001_CFG_WORD2 = 24'h123456;

endpackage

// File: rtl/msi001_cfg_sequencer.sv
// Walks an external register-word table and feeds each word to msi001_spi,
// waiting for its completion, spacing words by a gap and trapping a hung serializer.
module msi001_cfg_sequencer
    import msi001_pkg::*;
#(
    parameter int DATA_W         = MSI001_WORD_W,
    parameter int ADDR_W         = 4,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_idx,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    output logic [DATA_W-1:0] spi_data,
    output logic              spi_start,
    input  logic              spi_complete,
    output logic [2:0]        dbg_state
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [ADDR_W:0]  MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  ONE_WORD  = (ADDR_W + 1)'(1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    logic [2:0]        state;
    logic [ADDR_W:0]   n;
    logic [ADDR_W-1:0] idx;
    logic [TMR_W-1:0]  timer;
    logic [GAP_W-1:0]  gap_cnt;
    logic [ADDR_W:0]   n_sat;
    logic              last_word;

    assign n_sat     = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
    assign last_word = ({1'b0, idx} == (n - ONE_WORD));
    assign dbg_state = state;

    // Serializer handshake: spi_start is a one-cycle load pulse with spi_data
    // already valid and held through WAIT; spi_complete is a one-cycle pulse
    // that is only honoured while in WAIT, so stray or late pulses are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            n         <= '0;
            idx       <= '0;
            timer     <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_idx   <= '0;
            tbl_addr  <= '0;
            spi_data  <= '0;
            spi_start <= 1'b0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            spi_start <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            busy    <= 1'b1;
                            n       <= n_sat;
                            idx     <= '0;
                            err_idx <= '0;
                            if (num_words == '0) begin
                                state <= ST_DONE;
                            end else begin
                                tbl_addr <= '0;
                                state    <= ST_FETCH;
                            end
                        end
                    end
                    ST_FETCH: state <= ST_LOAD;
                    ST_LOAD: begin
                        spi_data  <= tbl_data;
                        spi_start <= 1'b1;
                        timer     <= '0;
                        state     <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (spi_complete) begin
                            if (last_word) begin
                                state <= ST_DONE;
                            end else begin
                                idx     <= idx + ADDR_W'(1);
                                gap_cnt <= '0;
                                state   <= ST_GAP;
                            end
                        end else if (timer == TMR_LAST) begin
                            state <= ST_ERR;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            tbl_addr <= idx;
                            state    <= ST_FETCH;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    ST_DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    ST_ERR: begin
                        err     <= 1'b1;
                        err_idx <= idx;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
